e203_itcm_loader: RTL and testbench

Streams a program image into the E203 ITCM as 64-bit words over an ICB write port, replacing the simulation-only backdoor preload with a synthesizable path. It sits upstream of the ITCM controller's external ICB slave port. A byte source such as a UART/JTAG bridge feeds it bytes. Byte k of the image lands at ITCM byte offset `base_addr + k`, little-endian within each 64-bit word, matching the `.verilog` image layout.

---
 rtl/e203_itcm_loader_pkg.sv | 17 +
 rtl/e203_itcm_loader_pack.sv | 31 +++
 rtl/e203_itcm_loader.sv | 143 ++++++++++++++
 tb/tb_e203_itcm_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/e203_itcm_loader_pkg.sv
// rtl/e203_itcm_loader_pkg.sv - shared state encoding and ICB word constants for the ITCM loader
package e203_itcm_loader_pkg;

    localparam int ITCM_LOADER_WORD_BYTES = 8;
    localparam int ICB_DW = 64;
    localparam int ICB_MW = ICB_DW / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_CMD,
        ST_RSP,
        ST_DONE,
        ST_ERR
    } loader_state_e;

endpackage

// File: rtl/e203_itcm_loader_pack.sv
// rtl/e203_itcm_loader_pack.sv - byte-lane packer building one little-endian 64-bit ICB write word
module e203_itcm_loader_pack
    import e203_itcm_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic [7:0]        push_data,
    output logic [ICB_DW-1:0] wdata,
    output logic [ICB_MW-1:0] wmask,
    output logic              last,
    output logic [2:0]        fill_idx
);

    // Unfilled lanes stay zero in both data and mask, so a partial tail word needs no masking later.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wdata    <= '0;
            wmask    <= '0;
            fill_idx <= '0;
        end else if (push) begin
            wdata[{fill_idx, 3'b000} +: 8] <= push_data;
            wmask[fill_idx]                <= 1'b1;
            fill_idx                       <= fill_idx + 3'd1;
        end
    end

    assign last = (fill_idx == 3'(ITCM_LOADER_WORD_BYTES - 1));

endmodule

// File: rtl/e203_itcm_loader.sv
// rtl/e203_itcm_loader.sv - streams a byte image into ITCM over ICB; E203_ITCM_LOADER_CHKSUM_EN enables the byte checksum
module e203_itcm_loader
    import e203_itcm_loader_pkg::*;
#(
    parameter int ITCM_AW = 16,
    parameter int LEN_W   = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ITCM_AW-1:0] base_addr,
    input  logic [LEN_W-1:0]   byte_len,
    input  logic               s_byte_valid,
    output logic               s_byte_ready,
    input  logic [7:0]         s_byte_data,
    output logic               icb_cmd_valid,
    input  logic               icb_cmd_ready,
    output logic [ITCM_AW-1:0] icb_cmd_addr,
    output logic               icb_cmd_read,
    output logic [ICB_DW-1:0]  icb_cmd_wdata,
    output logic [ICB_MW-1:0]  icb_cmd_wmask,
    input  logic               icb_rsp_valid,
    output logic               icb_rsp_ready,
    input  logic               icb_rsp_err,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [15:0]        words_written,
    output logic [31:0]        chksum
);

    localparam int SUM_W = ((ITCM_AW > LEN_W) ? ITCM_AW : LEN_W) + 1;

    loader_state_e      state, state_nxt;
    logic [LEN_W-1:0]   remaining;
    logic [ITCM_AW-1:0] addr;
    logic [SUM_W-1:0]   end_addr;
    logic               range_bad, start_acc, byte_acc, rsp_hs, pack_last;
    logic [2:0]         fill_idx;

    // End address is formed one bit wider than either operand so an oversized load cannot wrap into range.
    assign end_addr  = SUM_W'(base_addr) + SUM_W'(byte_len);
    assign range_bad = (end_addr > (SUM_W'(1) << ITCM_AW)) || (base_addr[2:0] != 3'd0);
    assign start_acc = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign byte_acc  = s_byte_valid && (state == ST_FILL);
    assign rsp_hs    = icb_rsp_valid && (state == ST_RSP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        s_byte_ready  = 1'b0;
        icb_cmd_valid = 1'b0;
        icb_rsp_ready = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        case (state)
            ST_FILL: begin
                s_byte_ready = 1'b1;
                busy         = 1'b1;
                if (byte_acc && (pack_last || remaining == LEN_W'(1))) state_nxt = ST_CMD;
            end
            ST_CMD: begin
                icb_cmd_valid = 1'b1;
                busy          = 1'b1;
                if (icb_cmd_ready) state_nxt = ST_RSP;
            end
            ST_RSP: begin
                icb_rsp_ready = 1'b1;
                busy          = 1'b1;
                if (icb_rsp_valid) begin
                    if (icb_rsp_err)          state_nxt = ST_ERR;
                    else if (remaining == '0) state_nxt = ST_DONE;
                    else                      state_nxt = ST_FILL;
                end
            end
            default: begin
                done = (state == ST_DONE);
                err  = (state == ST_ERR);
                if (start_acc) begin
                    if (range_bad)            state_nxt = ST_ERR;
                    else if (byte_len == '0)  state_nxt = ST_DONE;
                    else                      state_nxt = ST_FILL;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining     <= '0;
            addr          <= '0;
            words_written <= '0;
        end else if (start_acc) begin
            remaining     <= byte_len;
            addr          <= base_addr;
            words_written <= '0;
        end else begin
            if (byte_acc) remaining <= remaining - LEN_W'(1);
            if (rsp_hs && !icb_rsp_err) begin
                addr <= addr + ITCM_AW'(ITCM_LOADER_WORD_BYTES);
                if (words_written != 16'hFFFF) words_written <= words_written + 16'd1;
            end
        end
    end

    e203_itcm_loader_pack u_pack (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_acc || rsp_hs),
        .push      (byte_acc),
        .push_data (s_byte_data),
        .wdata     (icb_cmd_wdata),
        .wmask     (icb_cmd_wmask),
        .last      (pack_last),
        .fill_idx  (fill_idx)
    );

    assign icb_cmd_addr = addr;
    assign icb_cmd_read = 1'b0;

`ifdef E203_ITCM_LOADER_CHKSUM_EN
    logic [31:0] chksum_q;
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            chksum_q <= '0;
        end else if (byte_acc) begin
            chksum_q <= chksum_q + {24'd0, s_byte_data};
        end
    end
    assign chksum = chksum_q;
`else
    assign chksum = '0;
`endif

endmodule

// File: tb/tb_e203_itcm_loader.sv
// tb/tb_e203_itcm_loader.sv - directed self-checking bench for e203_itcm_loader
module tb_e203_itcm_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [19:0] byte_len = '0;
    logic        s_byte_valid = 1'b0;
    logic        s_byte_ready;
    logic [7:0]  s_byte_data = '0;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready = 1'b1;
    logic [15:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [63:0] icb_cmd_wdata;
    logic [7:0]  icb_cmd_wmask;
    logic        icb_rsp_valid = 1'b1;
    logic        icb_rsp_ready;
    logic        icb_rsp_err = 1'b0;
    logic        busy, done, err;
    logic [15:0] words_written;
    logic [31:0] chksum;

    int checks = 0;
    int errors = 0;

    logic [15:0] cap_addr  [4];
    logic [63:0] cap_wdata [4];
    logic [7:0]  cap_wmask [4];

    always #5 clk = ~clk;

    e203_itcm_loader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .byte_len(byte_len),
        .s_byte_valid(s_byte_valid), .s_byte_ready(s_byte_ready), .s_byte_data(s_byte_data),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_addr(icb_cmd_addr),
        .icb_cmd_read(icb_cmd_read), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_err(icb_rsp_err),
        .busy(busy), .done(done), .err(err), .words_written(words_written), .chksum(chksum)
    );

    // Drives one load with an always-ready ICB slave; records commands, bytes taken and cycles to done/err.
    task automatic do_load(input logic [15:0] base, input logic [19:0] len, input logic [7:0] b0,
                           input int err_at, output int ncmd, output int nsent, output int cyc);
        ncmd = 0; nsent = 0; cyc = -1;
        @(negedge clk); start = 1'b1; base_addr = base; byte_len = len;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 300 && cyc < 0; k++) begin
            if (done || err) begin
                cyc = k;
            end else begin
                if (icb_cmd_valid) begin
                    if (ncmd < 4) begin
                        cap_addr[ncmd]  = icb_cmd_addr;
                        cap_wdata[ncmd] = icb_cmd_wdata;
                        cap_wmask[ncmd] = icb_cmd_wmask;
                    end
                    ncmd++;
                end
                icb_rsp_err  = icb_rsp_ready && ((ncmd - 1) == err_at);
                s_byte_valid = (nsent < int'(len));
                s_byte_data  = b0 + 8'(nsent);
                if (s_byte_ready && nsent < int'(len)) nsent++;
                @(negedge clk);
            end
        end
        s_byte_valid = 1'b0;
        icb_rsp_err  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err, s_byte_ready, icb_cmd_valid, icb_rsp_ready, icb_cmd_read} !== 7'b0) begin
            errors++; $display("FAIL reset_flags got %b want 0", {busy, done, err, s_byte_ready, icb_cmd_valid, icb_rsp_ready, icb_cmd_read});
        end
        checks++;
        if ({icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask, words_written, chksum} !== '0) begin
            errors++; $display("FAIL reset_data got addr=%h wdata=%h mask=%h words=%h sum=%h want 0",
                               icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask, words_written, chksum);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_two_words();
        int n, s, c;
        logic [31:0] exp_sum;
`ifdef E203_ITCM_LOADER_CHKSUM_EN
        exp_sum = 32'h78;
`else
        exp_sum = 32'h0;
`endif
        do_load(16'h0000, 20'd16, 8'h00, -1, n, s, c);
        checks++; if (n !== 2) begin errors++; $display("FAIL two_ncmd got %0d want 2", n); end
        checks++; if (cap_addr[0] !== 16'h0000 || cap_wdata[0] !== 64'h0706050403020100 || cap_wmask[0] !== 8'hFF) begin
            errors++; $display("FAIL two_w0 got %h %h %h want 0000 0706050403020100 ff", cap_addr[0], cap_wdata[0], cap_wmask[0]); end
        checks++; if (cap_addr[1] !== 16'h0008 || cap_wdata[1] !== 64'h0F0E0D0C0B0A0908 || cap_wmask[1] !== 8'hFF) begin
            errors++; $display("FAIL two_w1 got %h %h %h want 0008 0f0e0d0c0b0a0908 ff", cap_addr[1], cap_wdata[1], cap_wmask[1]); end
        checks++; if (done !== 1'b1 || busy !== 1'b0 || words_written !== 16'd2) begin
            errors++; $display("FAIL two_status got done=%b busy=%b words=%0d want 1 0 2", done, busy, words_written); end
        checks++; if (chksum !== exp_sum) begin errors++; $display("FAIL two_chksum got %h want %h", chksum, exp_sum); end
        checks++; if (c !== 20) begin errors++; $display("FAIL two_cycles got %0d want 20", c); end
    endtask

    task automatic test_partial();
        int n, s, c;
        logic [31:0] exp_sum;
`ifdef E203_ITCM_LOADER_CHKSUM_EN
        exp_sum = 32'h717;
`else
        exp_sum = 32'h0;
`endif
        do_load(16'h0100, 20'd11, 8'hA0, -1, n, s, c);
        checks++; if (n !== 2 || cap_addr[0] !== 16'h0100 || cap_wdata[0] !== 64'hA7A6A5A4A3A2A1A0) begin
            errors++; $display("FAIL part_w0 got n=%0d %h %h want 2 0100 a7a6a5a4a3a2a1a0", n, cap_addr[0], cap_wdata[0]); end
        checks++; if (cap_addr[1] !== 16'h0108 || cap_wmask[1] !== 8'h07 || cap_wdata[1] !== 64'h0000000000AAA9A8) begin
            errors++; $display("FAIL part_w1 got %h %h %h want 0108 07 0000000000aaa9a8", cap_addr[1], cap_wmask[1], cap_wdata[1]); end
        checks++; if (done !== 1'b1 || words_written !== 16'd2 || chksum !== exp_sum) begin
            errors++; $display("FAIL part_status got done=%b words=%0d sum=%h want 1 2 %h", done, words_written, chksum, exp_sum); end
    endtask

    task automatic test_zero_and_misaligned();
        int n, s, c;
        do_load(16'h0040, 20'd0, 8'h00, -1, n, s, c);
        checks++; if (c !== 0 || done !== 1'b1 || err !== 1'b0 || n !== 0) begin
            errors++; $display("FAIL zero_len got cyc=%0d done=%b err=%b ncmd=%0d want 0 1 0 0", c, done, err, n); end
        do_load(16'h0004, 20'd8, 8'h00, -1, n, s, c);
        checks++; if (c !== 0 || err !== 1'b1 || done !== 1'b0 || n !== 0 || s !== 0) begin
            errors++; $display("FAIL misaligned got cyc=%0d err=%b done=%b ncmd=%0d bytes=%0d want 0 1 0 0 0", c, err, done, n, s); end
    endtask

    task automatic test_range();
        int n, s, c;
        do_load(16'hFFF8, 20'd9, 8'h30, -1, n, s, c);
        checks++; if (c !== 0 || err !== 1'b1 || n !== 0 || s !== 0) begin
            errors++; $display("FAIL range_over got cyc=%0d err=%b ncmd=%0d bytes=%0d want 0 1 0 0", c, err, n, s); end
        do_load(16'hFFF8, 20'd8, 8'h30, -1, n, s, c);
        checks++; if (done !== 1'b1 || n !== 1 || cap_addr[0] !== 16'hFFF8 || cap_wdata[0] !== 64'h3736353433323130) begin
            errors++; $display("FAIL range_edge got done=%b ncmd=%0d addr=%h wdata=%h want 1 1 fff8 3736353433323130",
                               done, n, cap_addr[0], cap_wdata[0]); end
    endtask

    task automatic test_backpressure();
        @(negedge clk); start = 1'b1; base_addr = 16'h0200; byte_len = 20'd8;
        @(negedge clk); start = 1'b0; icb_cmd_ready = 1'b0; s_byte_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_byte_data = 8'h10 + 8'(i);
            @(negedge clk);
        end
        s_byte_data = 8'hEE;
        checks++; if (icb_cmd_valid !== 1'b1) begin errors++; $display("FAIL bp_cmd_latency got %b want 1", icb_cmd_valid); end
        for (int h = 0; h < 5; h++) begin
            checks++;
            if (icb_cmd_valid !== 1'b1 || s_byte_ready !== 1'b0 || icb_cmd_addr !== 16'h0200 ||
                icb_cmd_wdata !== 64'h1716151413121110 || icb_cmd_wmask !== 8'hFF) begin
                errors++; $display("FAIL bp_hold%0d got v=%b rdy=%b %h %h %h want 1 0 0200 1716151413121110 ff",
                                   h, icb_cmd_valid, s_byte_ready, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask);
            end
            @(negedge clk);
        end
        icb_cmd_ready = 1'b1;
        @(negedge clk);
        checks++; if (icb_rsp_ready !== 1'b1 || icb_cmd_valid !== 1'b0) begin
            errors++; $display("FAIL bp_rsp got rsp_ready=%b cmd_valid=%b want 1 0", icb_rsp_ready, icb_cmd_valid); end
        @(negedge clk);
        s_byte_valid = 1'b0;
        checks++; if (done !== 1'b1 || words_written !== 16'd1) begin
            errors++; $display("FAIL bp_done got done=%b words=%0d want 1 1", done, words_written); end
    endtask

    task automatic test_rsp_err();
        int n, s, c;
        do_load(16'h0000, 20'd16, 8'h00, 0, n, s, c);
        checks++; if (err !== 1'b1 || done !== 1'b0 || n !== 1 || words_written !== 16'd0 || s !== 8) begin
            errors++; $display("FAIL rsp_err got err=%b done=%b ncmd=%0d words=%0d bytes=%0d want 1 0 1 0 8",
                               err, done, n, words_written, s); end
    endtask

    task automatic test_reset_midload();
        int n, s, c;
        logic [31:0] exp_sum;
`ifdef E203_ITCM_LOADER_CHKSUM_EN
        exp_sum = 32'h31C;
`else
        exp_sum = 32'h0;
`endif
        @(negedge clk); start = 1'b1; base_addr = 16'h0300; byte_len = 20'd8;
        @(negedge clk); start = 1'b0; s_byte_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_byte_data = 8'h50 + 8'(i);
            @(negedge clk);
        end
        s_byte_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, err, s_byte_ready, icb_cmd_valid, icb_rsp_ready} !== 6'b0 ||
            {icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask, words_written, chksum} !== '0) begin
            errors++; $display("FAIL midrst got flags=%b wdata=%h mask=%h addr=%h words=%0d sum=%h want 0",
                               {busy, done, err, s_byte_ready, icb_cmd_valid, icb_rsp_ready},
                               icb_cmd_wdata, icb_cmd_wmask, icb_cmd_addr, words_written, chksum);
        end
        rst = 1'b0;
        do_load(16'h0300, 20'd8, 8'h60, -1, n, s, c);
        checks++; if (done !== 1'b1 || n !== 1 || words_written !== 16'd1 || cap_addr[0] !== 16'h0300 ||
                      cap_wdata[0] !== 64'h6766656463626160 || chksum !== exp_sum) begin
            errors++; $display("FAIL midrst_reload got done=%b ncmd=%0d words=%0d addr=%h wdata=%h sum=%h want 1 1 1 0300 6766656463626160 %h",
                               done, n, words_written, cap_addr[0], cap_wdata[0], chksum, exp_sum); end
        checks++; if (c !== 10) begin errors++; $display("FAIL midrst_cycles got %0d want 10", c); end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_partial();
        test_zero_and_misaligned();
        test_range();
        test_backpressure();
        test_rsp_err();
        test_reset_midload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
